// File: rtl/alu_seq.sv
// alu_seq: single-beat ALU with one-cycle ops and iterative unsigned MUL/DIV behind valid/ready
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_dz,
    output logic             flag_err
);

    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_NEG = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               live_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic               z_q, z_d, c_q, c_d, v_q, v_d, dz_q, dz_d, err_q, err_d;

    logic               accept, is_mul, is_div, last, wr;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   dif;
    logic [WIDTH-1:0]   s_lo, s_hi;
    logic               s_c, s_v, s_dz, s_err;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_p;
    logic [WIDTH:0]     div_sh, div_df;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_p;

    assign accept = in_valid && in_ready;
    assign is_mul = opcode == OP_MUL;
    assign is_div = (opcode == OP_DIV) && (b != '0);
    assign last   = cnt_q == CNT_W'(1);

    // State register; live_q keeps in_ready low until the first edge out of reset
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    // Next-state: one op in flight, iterative ops stay for WIDTH steps, DONE waits for the consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = is_mul ? S_MUL : (is_div ? S_DIV : S_DONE);
            S_MUL:   if (last) state_d = S_DONE;
            S_DIV:   if (last) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle results straight from the request inputs
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        dif   = a - b;
        s_lo  = '0;
        s_hi  = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        s_dz  = 1'b0;
        s_err = 1'b0;
        case (opcode)
            OP_ADD: begin
                s_lo = sum[WIDTH-1:0];
                s_c  = sum[WIDTH];
                s_v  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                s_lo = dif;
                s_c  = a < b;
                s_v  = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHR: s_lo = a >> b;
            OP_SHL: s_lo = a << b;
            OP_AND: s_lo = a & b;
            OP_OR:  s_lo = a | b;
            OP_NEG: s_lo = ~a;
            OP_MUL: s_err = 1'b0;
            OP_DIV: begin
                s_lo = '1;
                s_hi = a;
                s_dz = 1'b1;
            end
            default: s_err = 1'b1;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide over the shared {hi,lo} register
    always_comb begin
        mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + ({1'b0, opd_q} & {(WIDTH+1){p_q[0]}});
        mul_p   = {mul_sum, p_q[WIDTH-1:1]};
        div_sh  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_df  = div_sh - {1'b0, opd_q};
        div_ge  = !div_df[WIDTH];
        div_p   = {div_ge ? div_df[WIDTH-1:0] : div_sh[WIDTH-1:0], p_q[WIDTH-2:0], div_ge};
    end

    // Datapath next-state: load on accept, iterate, and write the result registers once per op
    always_comb begin
        p_d   = p_q;
        cnt_d = cnt_q;
        opd_d = opd_q;
        lo_d  = lo_q;
        hi_d  = hi_q;
        c_d   = c_q;
        v_d   = v_q;
        dz_d  = dz_q;
        err_d = err_q;
        wr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    opd_d = is_mul ? a : b;
                    p_d   = {{WIDTH{1'b0}}, is_mul ? b : a};
                    cnt_d = CNT_W'(WIDTH);
                    if (!is_mul && !is_div) begin
                        lo_d  = s_lo;
                        hi_d  = s_hi;
                        c_d   = s_c;
                        v_d   = s_v;
                        dz_d  = s_dz;
                        err_d = s_err;
                        wr    = 1'b1;
                    end
                end
            end
            S_MUL: begin
                p_d   = mul_p;
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    {hi_d, lo_d} = mul_p;
                    {c_d, v_d, dz_d, err_d} = 4'b0000;
                    wr = 1'b1;
                end
            end
            S_DIV: begin
                p_d   = div_p;
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    {hi_d, lo_d} = div_p;
                    {c_d, v_d, dz_d, err_d} = 4'b0000;
                    wr = 1'b1;
                end
            end
            default: wr = 1'b0;
        endcase
        z_d = wr ? ~|{hi_d, lo_d} : z_q;
    end

    // Datapath registers; reset abandons any operation and clears the visible result
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            p_q   <= '0;
            cnt_q <= '0;
            opd_q <= '0;
            lo_q  <= '0;
            hi_q  <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            dz_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            cnt_q <= cnt_d;
            opd_q <= opd_d;
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            z_q   <= z_d;
            c_q   <= c_d;
            v_q   <= v_d;
            dz_q  <= dz_d;
            err_q <= err_d;
        end
    end

    // Handshake outputs decoded from state; result outputs straight from registers
    always_comb begin
        in_ready  = live_q && (state_q == S_IDLE);
        out_valid = state_q == S_DONE;
        res_lo    = lo_q;
        res_hi    = hi_q;
        flag_z    = z_q;
        flag_c    = c_q;
        flag_v    = v_q;
        flag_dz   = dz_q;
        flag_err  = err_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=8
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_b, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   opcode;
    logic [W-1:0] a, b, res_lo, res_hi;
    logic         flag_z, flag_c, flag_v, flag_dz, flag_err;
    int           total = 0;
    int           bad = 0;
    int           rdy_hi;
    logic [W-1:0] blo, bhi;
    logic         ok;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .res_lo(res_lo), .res_hi(res_hi), .flag_z(flag_z), .flag_c(flag_c),
        .flag_v(flag_v), .flag_dz(flag_dz), .flag_err(flag_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // flags order: {z, c, v, dz, err}
    task automatic chk_res(input string t, input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [4:0] fl);
        chk({t, "_lo"}, 16'(res_lo), 16'(lo));
        chk({t, "_hi"}, 16'(res_hi), 16'(hi));
        chk({t, "_flags"}, 16'({flag_z, flag_c, flag_v, flag_dz, flag_err}), 16'(fl));
    endtask

    task automatic run(input string t, input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int lat_exp, output int rh);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({t, "_ready"}, 16'(in_ready), 16'd1);
        opcode = op; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        opcode = 4'($urandom);
        lat = 1;
        rh = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rh++;
            @(posedge clk); #1;
            lat++;
        end
        chk({t, "_latency"}, 16'(lat), 16'(lat_exp));
    endtask

    task automatic xfer(input string t);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({t, "_valid_drop"}, 16'(out_valid), 16'd0);
        chk({t, "_ready_back"}, 16'(in_ready), 16'd1);
    endtask

    initial begin
        rst_b = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opcode = 4'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_ready", 16'(in_ready), 16'd0);
        chk_res("rst", 8'h00, 8'h00, 5'b00000);
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", 16'(in_ready), 16'd1);

        run("add1", 4'd3, 8'hF0, 8'h20, 1, rdy_hi);
        chk_res("add1", 8'h10, 8'h00, 5'b01000);
        xfer("add1");
        run("add2", 4'd3, 8'h7F, 8'h01, 1, rdy_hi);
        chk_res("add2", 8'h80, 8'h00, 5'b00100);
        xfer("add2");
        run("sub", 4'd4, 8'h05, 8'h07, 1, rdy_hi);
        chk_res("sub", 8'hFE, 8'h00, 5'b01000);
        xfer("sub");
        run("shl", 4'd6, 8'h81, 8'd1, 1, rdy_hi);
        chk_res("shl", 8'h02, 8'h00, 5'b00000);
        xfer("shl");
        run("shr", 4'd5, 8'h80, 8'd9, 1, rdy_hi);
        chk_res("shr", 8'h00, 8'h00, 5'b10000);
        xfer("shr");
        run("and", 4'd7, 8'hF0, 8'h3C, 1, rdy_hi);
        chk_res("and", 8'h30, 8'h00, 5'b00000);
        xfer("and");
        run("neg", 4'd9, 8'h0F, 8'hAA, 1, rdy_hi);
        chk_res("neg", 8'hF0, 8'h00, 5'b00000);
        xfer("neg");

        run("mul", 4'd10, 8'hFF, 8'hFF, 9, rdy_hi);
        chk("mul_ready_low", 16'(rdy_hi), 16'd0);
        chk_res("mul", 8'h01, 8'hFE, 5'b00000);
        blo = res_lo; bhi = res_hi; ok = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || res_lo !== blo || res_hi !== bhi) ok = 1'b0;
        end
        chk("bp_stable", 16'(ok), 16'd1);
        xfer("mul");
        chk_res("mul_hold", 8'h01, 8'hFE, 5'b00000);

        run("div", 4'd11, 8'd200, 8'd7, 9, rdy_hi);
        chk("div_ready_low", 16'(rdy_hi), 16'd0);
        chk_res("div", 8'd28, 8'd4, 5'b00000);
        xfer("div");
        run("divz", 4'd11, 8'h33, 8'h00, 1, rdy_hi);
        chk_res("divz", 8'hFF, 8'h33, 5'b00010);
        xfer("divz");

        opcode = 4'd11; a = 8'd200; b = 8'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(posedge clk); #1;
        chk("mrst_valid", 16'(out_valid), 16'd0);
        chk("mrst_ready", 16'(in_ready), 16'd0);
        chk_res("mrst", 8'h00, 8'h00, 5'b00000);
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("mrst_rel_ready", 16'(in_ready), 16'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("mrst_abandoned", 16'(out_valid), 16'd0);
        run("add3", 4'd3, 8'h12, 8'h34, 1, rdy_hi);
        chk_res("add3", 8'h46, 8'h00, 5'b00000);
        xfer("add3");

        run("ill", 4'd0, 8'h5A, 8'hA5, 1, rdy_hi);
        chk_res("ill", 8'h00, 8'h00, 5'b10001);
        opcode = 4'd3; a = 8'h01; b = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hs_valid_drop", 16'(out_valid), 16'd0);
        chk("hs_ready", 16'(in_ready), 16'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("hs_next_valid", 16'(out_valid), 16'd1);
        chk_res("hs_add", 8'h03, 8'h00, 5'b00000);
        xfer("hs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the project's 32-bit structural ALU.
- Takes both operands and an opcode in a single valid/ready beat instead of two ibus read cycles.
- Runs add, sub, shifts, logic and NOT in one cycle, and unsigned MUL/DIV as iterative WIDTH-cycle engines.
- Returns a double-width result plus status flags through a valid/ready output handshake with backpressure.

Parameters:
- WIDTH, 32, operand width in bits; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, internal iteration-counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset, synchronous, active-low.
- in_valid  in  1  request beat present.
- in_ready  out  1  block can accept a request.
- opcode  in  4  operation, same encoding as the existing ALU: ADD=3, SUB=4, SHR=5, SHL=6, AND=7, OR=8, NEG=9, MUL=10, DIV=11. All other codes are illegal.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- res_lo  out  WIDTH  main result; the quotient for DIV.
- res_hi  out  WIDTH  MUL upper half, or DIV remainder; 0 for all other ops.
- flag_z  out  1  {res_hi,res_lo}==0.
- flag_c  out  1  ADD carry-out; SUB borrow (a<b); 0 otherwise.
- flag_v  out  1  ADD/SUB signed overflow; 0 otherwise.
- flag_dz  out  1  DIV with b==0.
- flag_err  out  1  illegal opcode.

Behaviour:
- Reset (rst_b low at a rising clk edge) returns state to IDLE and clears in_ready, out_valid, res_lo, res_hi and all flags to 0. Reset mid-MUL/DIV or mid-DONE abandons the operation; no result is emitted.
- in_ready = 1 only in IDLE, so at most one operation is in flight. An accept is in_valid && in_ready at a clock edge; a, b and opcode are captured then.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, on accept with a single-cycle op (3-9, illegal, or DIV with b==0): compute, register the outputs, go to DONE. out_valid rises the cycle after accept, i.e. latency 1.
- IDLE, on accept with MUL: go to MUL. On DIV with b!=0: go to DIV. Counter loads WIDTH.
- MUL: radix-2 shift-add, one multiplier bit per cycle, counter decrements. When the counter reaches 0, register {res_hi,res_lo}=a*b (2*WIDTH bits, unsigned) and go to DONE. out_valid rises exactly WIDTH+1 cycles after accept.
- DIV: restoring division, one quotient bit per cycle. res_lo=a/b, res_hi=a%b (unsigned). Same WIDTH+1 latency.
- DONE: out_valid=1; outputs hold stable while out_ready=0. When out_valid && out_ready, go to IDLE, drop out_valid and re-raise in_ready the next cycle. Outputs keep their last value after the handshake.
- Arithmetic:
  - ADD: WIDTH+1-bit sum; carry goes to flag_c. flag_v = signs of a and b equal and sign of the result differs.
  - SUB: a-b mod 2^WIDTH. flag_c = (a<b). flag_v = signs of a and b differ and sign of the result differs from a.
  - SHR/SHL: logical shift of a by b. If b>=WIDTH (any bit above log2 range set), the result is 0.
  - AND/OR: bitwise. NEG: bitwise NOT of a; b is ignored.
- Divide by zero: res_lo=all ones, res_hi=a, flag_dz=1, latency 1.
- Illegal opcode (0,1,2,12-15): res_lo=res_hi=0, flag_err=1, flag_z=1, latency 1.
- flag_z is computed for every op from the final registered result.
- in_valid while in_ready=0 is ignored; the requester must hold the request until accepted. Inputs are not sampled outside accept cycles.
- Simultaneous out handshake and new in_valid: the new request is not accepted that cycle. It is accepted the following cycle, giving a throughput of one op per 2 cycles minimum.

Test Plan:
- WIDTH=8, ADD a=0xF0 b=0x20 -> out_valid 1 cycle after accept; res_lo=0x10, flag_c=1, flag_v=0. Then ADD a=0x7F b=0x01 -> 0x80, flag_v=1.
- WIDTH=8, SUB a=0x05 b=0x07 -> res_lo=0xFE, flag_c=1. SHL a=0x81 b=1 -> 0x02. SHR a=0x80 b=9 -> 0x00, flag_z=1.
- WIDTH=8, MUL a=0xFF b=0xFF -> out_valid exactly 9 cycles after accept; res_hi=0xFE, res_lo=0x01; in_ready=0 throughout.
- WIDTH=8, DIV a=200 b=7 -> 9-cycle latency, res_lo=28, res_hi=4. DIV a=0x33 b=0 -> 1-cycle latency, res_lo=0xFF, res_hi=0x33, flag_dz=1.
- Backpressure: hold out_ready=0 for 5 cycles after a MUL result -> out_valid and outputs stable, in_ready=0. Release -> one transfer, then in_ready=1 next cycle. Opcode 0 -> flag_err=1, result 0.
- Reset: assert rst_b=0 in the 4th cycle of a DIV -> next edge gives out_valid=0 and all outputs 0. After release, in_ready=1 and a fresh ADD returns correctly.
